// File: rtl/spike_packet_receiver.sv
// Spike packet receiver: buffers 24-bit {src, dest} packets in a FIFO, filters them by node ID and
// local index, and issues one accumulate request per match. Define SPIKE_RX_DROP_COUNT_EN to add drop_count.
module spike_packet_receiver #(
    parameter logic [7:0] NODE_ID     = 8'd0,
    parameter int         NUM_NEURONS = 10,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        clear,
    input  logic [23:0] packet,
    input  logic        packet_valid,
    output logic        packet_ready,
    output logic        acc_valid,
    input  logic        acc_ready,
    output logic [3:0]  acc_neuron_idx,
    output logic [11:0] acc_source_addr,
    output logic        busy
`ifdef SPIKE_RX_DROP_COUNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DECODE, ISSUE} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [23:0]      hold_q, hold_d;
    logic [3:0]       idx_q, idx_d;
    logic [11:0]      src_q, src_d;
    logic [23:0]      fifo_mem_q [FIFO_DEPTH];
    logic             push, pop, match;

    // A full FIFO refuses a push even on a pop edge, so readiness depends only on the registered count.
    assign packet_ready = (count_q != FULL_CNT) && !clear;
    assign push         = packet_valid && packet_ready;
    assign pop          = (state_q == IDLE) && (count_q != '0) && !clear;
    assign match        = (hold_q[11:4] == NODE_ID) && (32'(hold_q[3:0]) < NUM_NEURONS);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (count_q != '0) state_d = DECODE;
                DECODE:  state_d = match ? ISSUE : IDLE;
                ISSUE:   if (acc_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        src_d    = src_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                hold_d   = fifo_mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (state_q == DECODE && match) begin
                idx_d = hold_q[3:0];
                src_d = hold_q[23:12];
            end
        end
    end

    always_comb begin
        acc_valid       = (state_q == ISSUE);
        acc_neuron_idx  = idx_q;
        acc_source_addr = src_q;
        busy            = (count_q != '0) || (state_q != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it was written, and this keeps it RAM-mappable.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= packet;
    end

`ifdef SPIKE_RX_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (state_q == DECODE && !match && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Scoreboard bench for spike_packet_receiver: directed boundary scenarios plus randomized traffic
// checked against a queue-based reference of accepted, matching packets.
module tb_spike_packet_receiver;

    localparam logic [7:0] NODE_ID     = 8'd0;
    localparam int         NUM_NEURONS = 10;
    localparam int         FIFO_DEPTH  = 8;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        clear;
    logic [23:0] packet;
    logic        packet_valid;
    logic        packet_ready;
    logic        acc_valid;
    logic        acc_ready;
    logic [3:0]  acc_neuron_idx;
    logic [11:0] acc_source_addr;
    logic        busy;
`ifdef SPIKE_RX_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    spike_packet_receiver #(
        .NODE_ID(NODE_ID), .NUM_NEURONS(NUM_NEURONS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .clear(clear),
        .packet(packet), .packet_valid(packet_valid), .packet_ready(packet_ready),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_neuron_idx(acc_neuron_idx), .acc_source_addr(acc_source_addr),
        .busy(busy)
`ifdef SPIKE_RX_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_issued = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference rule: a packet yields a request iff it targets this node and an existing neuron.
    function automatic bit exp_match(input logic [23:0] p);
        return (p[11:4] == NODE_ID) && (int'(p[3:0]) < NUM_NEURONS);
    endfunction

    // Monitor: samples mid-cycle, retires handshakes against the scoreboard, then records new accepts.
    always @(negedge CLK) begin
        if (!RESET_N || clear) begin
            exp_q.delete();
        end else begin
            if (acc_valid && acc_ready) begin
                n_issued++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {16'h0, acc_neuron_idx, acc_source_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("acc_req", {16'h0, acc_neuron_idx, acc_source_addr}, {16'h0, exp_q.pop_front()});
                end
            end
            if (packet_valid && packet_ready && exp_match(packet))
                exp_q.push_back({packet[3:0], packet[23:12]});
        end
    end

    function automatic logic [23:0] good_pkt();
        return {12'($urandom), NODE_ID, 4'($urandom_range(0, NUM_NEURONS - 1))};
    endfunction

    task automatic send(input logic [23:0] p);
        bit done = 0;
        packet = p;
        packet_valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (packet_ready) done = 1;
            @(posedge CLK); #1;
        end
        packet_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // Offers up to `want` matching packets back to back; reports how many were accepted.
    task automatic fill(input int want, input int budget, output int got);
        got = 0;
        packet = good_pkt();
        packet_valid = 1'b1;
        for (int c = 0; c < budget && got < want; c++) begin
            @(negedge CLK);
            if (packet_ready) got++;
            @(posedge CLK); #1;
            if (packet_ready || got > 0) packet = good_pkt();
        end
        packet_valid = 1'b0;
    endtask

    task automatic wait_acc(input string name);
        bit seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge CLK);
            if (acc_valid) seen = 1;
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic drain(input string name);
        packet_valid = 1'b0;
        acc_ready = 1'b1;
        for (int c = 0; c < 300 && (exp_q.size() != 0 || busy); c++) @(posedge CLK);
        #1;
        check(name, exp_q.size(), 0);
        check({name, "_busy"}, busy, 0);
    endtask

    int got;
    int issued_before;

    initial begin
        RESET_N = 1'b0; clear = 1'b0; packet = '0; packet_valid = 1'b0; acc_ready = 1'b1;
        #1;
        check("rst_acc_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", acc_neuron_idx, 0);
        check("rst_src", acc_source_addr, 0);
        #20; RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("rst_packet_ready", packet_ready, 1);

        // Single packet latency: accept at e0, request visible after e2.
        send({12'h015, 12'h003});
        check("lat_e0_valid", acc_valid, 0);
        @(posedge CLK); #1;
        check("lat_e1_valid", acc_valid, 0);
        @(posedge CLK); #1;
        check("lat_e2_valid", acc_valid, 1);
        check("lat_idx", acc_neuron_idx, 3);
        check("lat_src", acc_source_addr, 12'h015);
        @(posedge CLK); #1;
        check("lat_done_valid", acc_valid, 0);
        check("lat_done_busy", busy, 0);

        // Filter: wrong node and out-of-range index are both dropped.
        issued_before = n_issued;
        send({12'h0A1, 12'h013});
        send({12'h0A2, 12'h00C});
        repeat (10) @(posedge CLK); #1;
        check("filter_no_req", n_issued - issued_before, 0);
        check("filter_busy", busy, 0);
`ifdef SPIKE_RX_DROP_COUNT_EN
        check("filter_drop_count", drop_count, 2);
`endif

        // Back-pressure: one packet in hold plus a full FIFO.
        acc_ready = 1'b0;
        fill(10, 20, got);
        check("bp_accepts", got, FIFO_DEPTH + 1);
        check("bp_ready_low", packet_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_pending", exp_q.size(), FIFO_DEPTH + 1);
        drain("bp_drain");

        // Full boundary: no push on the pop edge, push on the following cycle.
        acc_ready = 1'b0;
        fill(9, 20, got);
        check("full_accepts", got, FIFO_DEPTH + 1);
        packet = good_pkt();
        packet_valid = 1'b1;
        acc_ready = 1'b1;
        wait_acc("full_wait_issue");
        @(negedge CLK);
        check("full_no_push_on_pop", packet_ready, 0);
        @(negedge CLK);
        check("full_push_after_pop", packet_ready, 1);
        @(posedge CLK); #1;
        packet_valid = 1'b0;
        drain("full_drain");

        // Clear while a request is pending.
        acc_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(good_pkt());
        wait_acc("clr_wait_issue");
        @(posedge CLK); #1;
        clear = 1'b1;
        packet = good_pkt();
        packet_valid = 1'b1;
        #1;
        check("clr_packet_ready", packet_ready, 0);
        @(posedge CLK); #1;
        clear = 1'b0;
        packet_valid = 1'b0;
        check("clr_acc_valid", acc_valid, 0);
        check("clr_busy", busy, 0);
`ifdef SPIKE_RX_DROP_COUNT_EN
        check("clr_drop_count", drop_count, 0);
`endif
        issued_before = n_issued;
        acc_ready = 1'b1;
        repeat (12) @(posedge CLK); #1;
        check("clr_no_req", n_issued - issued_before, 0);

        // Asynchronous reset while in ISSUE.
        acc_ready = 1'b0;
        send(good_pkt());
        send(good_pkt());
        wait_acc("arst_wait_issue");
        @(posedge CLK); #3;
        RESET_N = 1'b0;
        #1;
        check("arst_acc_valid", acc_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge CLK); @(negedge CLK); #2;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("arst_busy_after", busy, 0);
        check("arst_ready_after", packet_ready, 1);
        issued_before = n_issued;
        acc_ready = 1'b1;
        repeat (12) @(posedge CLK); #1;
        check("arst_no_req", n_issued - issued_before, 0);

        // Randomized traffic with back-pressure and occasional clears.
        repeat (600) begin
            packet_valid = 1'($urandom_range(0, 1));
            packet = ($urandom_range(0, 2) != 0) ? {12'($urandom), NODE_ID, 4'($urandom_range(0, 15))}
                                                 : 24'($urandom);
            acc_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 59) == 0);
            @(posedge CLK); #1;
        end
        clear = 1'b0;
        drain("rand_drain");
        check("rand_some_issued", (n_issued > 20), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
